axi_lite_mem_adapter: RTL and testbench

- AXI-Lite device that terminates the AXI-Lite host port of the TL-UL to AXI-Lite bridge.
- Drives a single-port synchronous SRAM with 1-cycle read latency.
- Serialises reads and writes: one transaction in flight. Fair read/write arbitration.
- Out-of-range addresses return SLVERR, which the upstream bridge maps to TL `denied`.

---
 rtl/axi_lite_mem_adapter.sv | 143 ++++++++++++++
 tb/tb_axi_lite_mem_adapter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_adapter.sv
// AXI-Lite device port onto a single-port synchronous SRAM with 1-cycle read latency.
// One transaction in flight; reads and writes alternate when both are pending.
module axi_lite_mem_adapter #(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned AddrWidth    = 56,
  parameter int unsigned MemAddrWidth = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      host_aw_valid,
  output logic                      host_aw_ready,
  input  logic [AddrWidth-1:0]      host_aw_addr,
  input  logic [2:0]                host_aw_prot,
  input  logic                      host_w_valid,
  output logic                      host_w_ready,
  input  logic [DataWidth-1:0]      host_w_data,
  input  logic [DataWidth/8-1:0]    host_w_strb,
  output logic                      host_b_valid,
  input  logic                      host_b_ready,
  output logic [1:0]                host_b_resp,
  input  logic                      host_ar_valid,
  output logic                      host_ar_ready,
  input  logic [AddrWidth-1:0]      host_ar_addr,
  input  logic [2:0]                host_ar_prot,
  output logic                      host_r_valid,
  input  logic                      host_r_ready,
  output logic [DataWidth-1:0]      host_r_data,
  output logic [1:0]                host_r_resp,

  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [DataWidth/8-1:0]    mem_wmask_o,
  input  logic [DataWidth-1:0]      mem_rdata_i
);

  localparam int unsigned ByteOffW = $clog2(DataWidth / 8);
  localparam int unsigned WordHi   = MemAddrWidth + ByteOffW;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StWResp, StRData, StRHold} state_e;

  state_e               state_q, state_d;
  logic                 last_wr_q, last_wr_d;
  logic [1:0]           resp_q, resp_d;
  logic                 rd_err_q, rd_err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic aw_in_range, ar_in_range;
  logic wr_elig, rd_elig, grant_wr, grant_rd;

  logic unused_prot;
  assign unused_prot = ^{host_aw_prot, host_ar_prot};

  assign aw_in_range = (host_aw_addr >> WordHi) == '0;
  assign ar_in_range = (host_ar_addr >> WordHi) == '0;

  // A write needs both AW and W; on a tie the side that lost last time wins.
  assign wr_elig  = host_aw_valid && host_w_valid;
  assign rd_elig  = host_ar_valid;
  assign grant_wr = (state_q == StIdle) && wr_elig && (!rd_elig || !last_wr_q);
  assign grant_rd = (state_q == StIdle) && rd_elig && !grant_wr;

  assign mem_addr_o  = grant_wr ? host_aw_addr[WordHi-1:ByteOffW]
                                : host_ar_addr[WordHi-1:ByteOffW];
  assign mem_wdata_o = host_w_data;
  assign mem_wmask_o = host_w_strb;
  assign host_b_resp = resp_q;
  assign host_r_resp = resp_q;

  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    resp_d        = resp_q;
    rd_err_d      = rd_err_q;
    rdata_d       = rdata_q;
    host_aw_ready = 1'b0;
    host_w_ready  = 1'b0;
    host_ar_ready = 1'b0;
    host_b_valid  = 1'b0;
    host_r_valid  = 1'b0;
    host_r_data   = rdata_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          host_aw_ready = 1'b1;
          host_w_ready  = 1'b1;
          mem_req_o     = aw_in_range;
          mem_we_o      = 1'b1;
          resp_d        = aw_in_range ? RespOkay : RespSlvErr;
          last_wr_d     = 1'b1;
          state_d       = StWResp;
        end else if (grant_rd) begin
          host_ar_ready = 1'b1;
          mem_req_o     = ar_in_range;
          resp_d        = ar_in_range ? RespOkay : RespSlvErr;
          rd_err_d      = !ar_in_range;
          last_wr_d     = 1'b0;
          state_d       = StRData;
        end
      end
      StWResp: begin
        host_b_valid = 1'b1;
        if (host_b_ready) state_d = StIdle;
      end
      StRData: begin
        // SRAM data is only valid this cycle; keep a copy in case R stalls.
        host_r_valid = 1'b1;
        host_r_data  = rd_err_q ? '0 : mem_rdata_i;
        rdata_d      = host_r_data;
        state_d      = host_r_ready ? StIdle : StRHold;
      end
      StRHold: begin
        host_r_valid = 1'b1;
        if (host_r_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      resp_q    <= RespOkay;
      rd_err_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      resp_q    <= resp_d;
      rd_err_q  <= rd_err_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_adapter.sv
// Randomised self-checking bench for axi_lite_mem_adapter against a transaction-level model
// (expected memory image, tie-break rule, response codes) plus a behavioural SRAM.
module tb_axi_lite_mem_adapter;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 56;
  localparam int unsigned MAW = 12;
  localparam int unsigned SW  = DW / 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           host_aw_valid = 0, host_aw_ready;
  logic [AW-1:0]  host_aw_addr = '0;
  logic [2:0]     host_aw_prot = '0;
  logic           host_w_valid = 0, host_w_ready;
  logic [DW-1:0]  host_w_data = '0;
  logic [SW-1:0]  host_w_strb = '0;
  logic           host_b_valid, host_b_ready = 0;
  logic [1:0]     host_b_resp;
  logic           host_ar_valid = 0, host_ar_ready;
  logic [AW-1:0]  host_ar_addr = '0;
  logic [2:0]     host_ar_prot = '0;
  logic           host_r_valid, host_r_ready = 0;
  logic [DW-1:0]  host_r_data;
  logic [1:0]     host_r_resp;
  logic           mem_req_o, mem_we_o;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0]  mem_wdata_o;
  logic [SW-1:0]  mem_wmask_o;
  logic [DW-1:0]  mem_rdata_i;

  axi_lite_mem_adapter #(.DataWidth(DW), .AddrWidth(AW), .MemAddrWidth(MAW)) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .host_aw_valid (host_aw_valid),
    .host_aw_ready (host_aw_ready),
    .host_aw_addr  (host_aw_addr),
    .host_aw_prot  (host_aw_prot),
    .host_w_valid  (host_w_valid),
    .host_w_ready  (host_w_ready),
    .host_w_data   (host_w_data),
    .host_w_strb   (host_w_strb),
    .host_b_valid  (host_b_valid),
    .host_b_ready  (host_b_ready),
    .host_b_resp   (host_b_resp),
    .host_ar_valid (host_ar_valid),
    .host_ar_ready (host_ar_ready),
    .host_ar_addr  (host_ar_addr),
    .host_ar_prot  (host_ar_prot),
    .host_r_valid  (host_r_valid),
    .host_r_ready  (host_r_ready),
    .host_r_data   (host_r_data),
    .host_r_resp   (host_r_resp),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wmask_o   (mem_wmask_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd,
                                          logic [SW-1:0] m);
    logic [DW-1:0] r = old;
    for (int i = 0; i < SW; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Behavioural SRAM; read data is garbage except the cycle after a read strobe.
  logic [DW-1:0] sram [2**MAW];
  always_ff @(posedge clk_i) begin
    if (mem_req_o && mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o,
                                                         mem_wmask_o);
    if (mem_req_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
    else                        mem_rdata_i <= {$urandom, $urandom};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  logic [DW-1:0]  ref_mem [2**MAW];
  int unsigned    pool [32];
  bit             last_wr;
  bit             wr_pend, rd_pend;
  logic [AW-1:0]  w_addr, r_addr;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  int             w_lag, b_stall, r_stall;

  function automatic bit in_range(logic [AW-1:0] a);
    return a < (AW'(1) << (MAW + 3));
  endfunction

  function automatic logic [MAW-1:0] widx(logic [AW-1:0] a);
    return MAW'(a / 8);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a = AW'(pool[$urandom_range(0, 31)]) * 8 + AW'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) a = a | (AW'(1) << $urandom_range(MAW + 3, AW - 1));
    return a;
  endfunction

  // Present the pending requests until one is granted, then complete its response.
  task automatic serve_one();
    bit exp_wr, exp_rd, exp_req;
    int guard = 0;
    int stall;
    logic [DW-1:0] exp_data;
    logic [1:0] exp_resp;
    exp_wr = 0;
    exp_rd = 0;
    while (!(exp_wr || exp_rd)) begin
      @(posedge clk_i); #1;
      host_b_ready  = 0;
      host_r_ready  = 0;
      host_aw_valid = wr_pend;
      host_w_valid  = wr_pend && (w_lag == 0);
      host_ar_valid = rd_pend;
      host_aw_addr  = w_addr;
      host_w_data   = w_data;
      host_w_strb   = w_strb;
      host_ar_addr  = r_addr;
      @(negedge clk_i);
      exp_wr  = host_aw_valid && host_w_valid && (!host_ar_valid || !last_wr);
      exp_rd  = host_ar_valid && !exp_wr;
      exp_req = exp_wr ? in_range(w_addr) : (exp_rd ? in_range(r_addr) : 1'b0);
      check_eq("idle_b_valid", DW'(host_b_valid), '0);
      check_eq("idle_r_valid", DW'(host_r_valid), '0);
      check_eq("aw_ready", DW'(host_aw_ready), DW'(exp_wr));
      check_eq("w_ready", DW'(host_w_ready), DW'(exp_wr));
      check_eq("ar_ready", DW'(host_ar_ready), DW'(exp_rd));
      check_eq("mem_req", DW'(mem_req_o), DW'(exp_req));
      if (exp_req) begin
        check_eq("mem_we", DW'(mem_we_o), DW'(exp_wr));
        check_eq("mem_addr", DW'(mem_addr_o), DW'(widx(exp_wr ? w_addr : r_addr)));
        if (exp_wr) begin
          check_eq("mem_wdata", mem_wdata_o, w_data);
          check_eq("mem_wmask", DW'(mem_wmask_o), DW'(w_strb));
        end
      end
      if (w_lag > 0) w_lag--;
      guard++;
      if (!(exp_wr || exp_rd) && guard > 10) begin
        n_checks++;
        n_fail++;
        $display("FAIL grant_timeout: no grant after %0d cycles", guard);
        return;
      end
    end

    if (exp_wr) begin
      if (in_range(w_addr)) ref_mem[widx(w_addr)] = merge(ref_mem[widx(w_addr)], w_data, w_strb);
      exp_resp = in_range(w_addr) ? 2'b00 : 2'b10;
      last_wr  = 1;
      wr_pend  = 0;
      stall    = b_stall;
      @(posedge clk_i); #1;
      host_aw_valid = 0;
      host_w_valid  = 0;
      host_b_ready  = (stall == 0);
      forever begin
        @(negedge clk_i);
        check_eq("b_valid", DW'(host_b_valid), 1);
        check_eq("b_resp", DW'(host_b_resp), DW'(exp_resp));
        check_eq("busy_ar_ready", DW'(host_ar_ready), '0);
        if (stall == 0) break;
        @(posedge clk_i); #1;
        stall--;
        host_b_ready = (stall == 0);
      end
    end else begin
      exp_data = in_range(r_addr) ? ref_mem[widx(r_addr)] : '0;
      exp_resp = in_range(r_addr) ? 2'b00 : 2'b10;
      last_wr  = 0;
      rd_pend  = 0;
      stall    = r_stall;
      @(posedge clk_i); #1;
      host_ar_valid = 0;
      host_r_ready  = (stall == 0);
      forever begin
        @(negedge clk_i);
        check_eq("r_valid", DW'(host_r_valid), 1);
        check_eq("r_data", host_r_data, exp_data);
        check_eq("r_resp", DW'(host_r_resp), DW'(exp_resp));
        check_eq("busy_aw_ready", DW'(host_aw_ready), '0);
        check_eq("busy_mem_req", DW'(mem_req_o), '0);
        if (stall == 0) break;
        @(posedge clk_i); #1;
        stall--;
        host_r_ready = (stall == 0);
      end
    end
  endtask

  task automatic post_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input int lag, input int stall);
    wr_pend = 1; w_addr = a; w_data = d; w_strb = s; w_lag = lag; b_stall = stall;
  endtask

  task automatic post_read(input logic [AW-1:0] a, input int stall);
    rd_pend = 1; r_addr = a; r_stall = stall;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    last_wr = 0; wr_pend = 0; rd_pend = 0; w_lag = 0;
    for (int i = 0; i < 32; i++) pool[i] = $urandom_range(0, 2**MAW - 1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    check_eq("rst_aw_ready", DW'(host_aw_ready), '0);
    check_eq("rst_ar_ready", DW'(host_ar_ready), '0);
    check_eq("rst_b_valid", DW'(host_b_valid), '0);
    check_eq("rst_r_valid", DW'(host_r_valid), '0);
    check_eq("rst_mem_req", DW'(mem_req_o), '0);
    check_eq("rst_resp", DW'({host_b_resp, host_r_resp}), '0);

    // Directed: write then stalled read of word 2
    post_write(56'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0);
    serve_one();
    post_read(56'h10, 3);
    serve_one();

    // AW and AR together while W lags: read goes first, write once W arrives
    post_write(56'h18, 64'h1122_3344_5566_7788, 8'h0F, 2, 1);
    post_read(56'h10, 0);
    serve_one();
    check_eq("lag_read_first", DW'(wr_pend), 1);
    serve_one();
    post_read(56'h18, 0);
    serve_one();

    // Out-of-range write and read
    post_write(AW'(1) << (MAW + 3), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    post_read(AW'(1) << (MAW + 3), 1);
    serve_one();
    serve_one();

    // Prefill the random address pool, then random mixed traffic
    for (int i = 0; i < 32; i++) begin
      post_write(AW'(pool[i]) * 8, {$urandom, $urandom}, 8'hFF, 0, 0);
      serve_one();
    end
    for (int n = 0; n < 200; n++) begin
      if (!wr_pend && $urandom_range(0, 2) != 0)
        post_write(rand_addr(), {$urandom, $urandom}, SW'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                   $urandom_range(0, 2));
      if (!rd_pend && $urandom_range(0, 2) != 0) post_read(rand_addr(), $urandom_range(0, 2));
      if (!wr_pend && !rd_pend) post_read(rand_addr(), $urandom_range(0, 2));
      serve_one();
    end
    while (wr_pend || rd_pend) serve_one();

    // Reset asserted while a read response is stalled
    @(posedge clk_i); #1;
    host_b_ready = 0; host_r_ready = 0;
    host_ar_valid = 1; host_ar_addr = AW'(pool[0]) * 8;
    @(negedge clk_i);
    check_eq("rh_ar_ready", DW'(host_ar_ready), 1);
    @(posedge clk_i); #1;
    host_ar_valid = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rh_r_valid", DW'(host_r_valid), 1);
    #2 rst_ni = 0;
    #1;
    check_eq("rh_async_drop", DW'(host_r_valid), '0);
    @(negedge clk_i);
    rst_ni = 1;
    last_wr = 0;
    post_write(AW'(pool[1]) * 8, 64'hCAFE_F00D_0BAD_5EED, 8'hA5, 0, 0);
    post_read(AW'(pool[1]) * 8, 0);
    serve_one();
    check_eq("post_rst_write_first", DW'(wr_pend), '0);
    serve_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
